// File: rtl/hilbert_fir_engine.sv
// Serial-MAC FIR engine: one product per cycle over a circular delay line.
// In Hilbert mode only the odd taps are processed.
module hilbert_fir_engine #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int TAPS = 16,
  localparam int AW   = $clog2(TAPS),
  localparam int ACCW = DW + CW + AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic signed [CW-1:0]   coef_data,
  input  logic                   mode,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic signed [DW-1:0]   in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic signed [ACCW-1:0] out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // out_valid/out_data stay stable until out_ready, in_ready is only high in IDLE.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    MAC   = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                   state;
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            k;
  logic [AW-1:0]            clr_cnt;
  logic                     mode_r;
  logic signed [ACCW-1:0]   acc;
  logic signed [DW-1:0]     x_mem [TAPS];
  logic signed [CW-1:0]     h_mem [TAPS];

  logic [AW-1:0]            rd_idx;
  logic signed [DW+CW-1:0]  prod;
  logic signed [ACCW-1:0]   acc_next;

  // Index arithmetic wraps naturally in AW bits, giving (wr_ptr - k) mod TAPS.
  assign rd_idx   = wr_ptr - k;
  assign prod     = x_mem[rd_idx] * h_mem[k];
  assign acc_next = acc + {{AW{prod[DW+CW-1]}}, prod};

  assign in_ready  = (state == IDLE) && !clear;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      k         <= '0;
      clr_cnt   <= '0;
      mode_r    <= 1'b0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_mem[i] <= '0;
        h_mem[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we) h_mem[coef_addr] <= coef_data;
          if (clear) begin
            clr_cnt <= '0;
            state   <= CLEAR;
          end else if (in_valid) begin
            x_mem[wr_ptr] <= in_data;
            mode_r        <= mode;
            acc           <= '0;
            k             <= mode ? AW'(1) : AW'(0);
            state         <= MAC;
          end
        end
        CLEAR: begin
          x_mem[clr_cnt] <= '0;
          clr_cnt        <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(TAPS - 1)) begin
            wr_ptr <= '0;
            state  <= IDLE;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + (mode_r ? AW'(2) : AW'(1));
          if (k == AW'(TAPS - 1)) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            wr_ptr    <= wr_ptr + AW'(1);
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilbert_fir_engine.sv
// Directed bench for hilbert_fir_engine: impulse tables for both modes,
// backpressure, clear, mid-MAC reset and full-scale accumulation.
module tb_hilbert_fir_engine;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 16;
  localparam int AW   = 4;
  localparam int ACCW = DW + CW + AW;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   coef_we = 1'b0;
  logic [AW-1:0]          coef_addr = '0;
  logic signed [CW-1:0]   coef_data = '0;
  logic                   mode = 1'b0;
  logic                   clear = 1'b0;
  logic                   in_valid = 1'b0;
  logic signed [DW-1:0]   in_data = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic signed [ACCW-1:0] out_data;
  logic                   out_ready = 1'b1;
  logic                   busy;
  logic                   done;
  logic [1:0]             state_dbg;

  int checks   = 0;
  int failures = 0;

  hilbert_fir_engine #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .mode(mode), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic            m;
    logic [DW-1:0]   d;
    logic [ACCW-1:0] exp_out;
    int              exp_lat;
  } vec_t;

  vec_t tbl [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input logic [CW-1:0] data);
    coef_we   = 1'b1;
    coef_addr = addr[AW-1:0];
    coef_data = data;
    tick();
    coef_we   = 1'b0;
  endtask

  // Offer one sample, wait (bounded) for its result and complete the handshake.
  task automatic run_sample(input logic m, input logic [DW-1:0] d,
                            output logic [ACCW-1:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    mode     = m;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    res = out_data;
    tick();
  endtask

  initial begin
    logic [ACCW-1:0] res;
    int              lat;
    int              n;
    logic            seen;

    for (int i = 0; i < 16; i++) begin
      tbl[i].m       = 1'b0;
      tbl[i].d       = (i == 0) ? 16'd1 : 16'd0;
      tbl[i].exp_out = ACCW'(i + 1);
      tbl[i].exp_lat = 17;
    end
    for (int i = 16; i < 32; i++) begin
      tbl[i].m       = 1'b1;
      tbl[i].d       = (i == 16) ? 16'd1 : 16'd0;
      tbl[i].exp_out = ((i - 16) % 2 == 1) ? ACCW'(100) : ACCW'(0);
      tbl[i].exp_lat = 9;
    end

    // Reset values
    #2;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_done", 64'(done), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_out_data", 64'(out_data), 0);
    tick();
    tick();
    rst_n = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 1);
    clear = 1'b1;
    #1;
    check("in_ready_clear_masked", 64'(in_ready), 0);
    clear = 1'b0;
    #1;

    // Impulse tables: full FIR with h[k]=k+1, then Hilbert with h odd=100/even=500
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'(k + 1));
    for (int i = 0; i < 32; i++) begin
      if (i == 16)
        for (int k = 0; k < TAPS; k++) write_coef(k, (k % 2 == 1) ? 16'sd100 : 16'sd500);
      run_sample(tbl[i].m, tbl[i].d, res, lat);
      check($sformatf("tbl_out[%0d]", i), 64'(res), 64'(tbl[i].exp_out));
      check($sformatf("tbl_lat[%0d]", i), 64'(lat), 64'(tbl[i].exp_lat));
    end

    // Backpressure with a mode flip after accept: x[0]=3 -> 3*h[0]=1500
    out_ready = 1'b0;
    mode      = 1'b0;
    in_data   = 16'sd3;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    mode     = 1'b1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("bp_lat", 64'(lat), 17);
    for (int c = 0; c < 20; c++) begin
      check("bp_hold_valid", 64'(out_valid), 1);
      check("bp_hold_data", 64'(out_data), 1500);
      check("bp_in_ready", 64'(in_ready), 0);
      check("bp_no_done", 64'(done), 0);
      tick();
    end
    out_ready = 1'b1;
    mode      = 1'b0;
    tick();
    check("bp_done_pulse", 64'(done), 1);
    check("bp_valid_drop", 64'(out_valid), 0);
    tick();
    check("bp_done_single", 64'(done), 0);

    // Fill with full-scale samples, then clear together with in_valid
    for (int i = 0; i < 16; i++) run_sample(1'b0, 16'h7FFF, res, lat);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd5;
    #1;
    check("clr_in_ready", 64'(in_ready), 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("clr_busy_cycles", 64'(n), 16);
    check("clr_no_output", 64'(out_valid), 0);
    run_sample(1'b0, 16'sd1, res, lat);
    check("clr_imp0", 64'(res), 500);
    run_sample(1'b0, 16'sd0, res, lat);
    check("clr_imp1", 64'(res), 100);

    // Reset asserted at MAC cycle 5
    in_data  = 16'sd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("pre_rst_busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_done", 64'(done), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_out_data", 64'(out_data), 0);
    check("mid_rst_state", 64'(state_dbg), 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid || done) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_output", 64'(seen), 0);

    // Reload taps; h[0]=3 written in the accept cycle applies to that sample
    for (int k = 1; k < TAPS; k++) write_coef(k, CW'(k + 1));
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = 16'sd3;
    in_data   = 16'sd7;
    in_valid  = 1'b1;
    mode      = 1'b0;
    tick();
    in_valid  = 1'b0;
    coef_data = 16'sd50;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    coef_we = 1'b0;
    check("post_rst_out", 64'(out_data), 21);
    check("post_rst_lat", 64'(lat), 17);
    tick();
    // The write of 50 during MAC/OUT must have been ignored: 1*3 + 7*2
    run_sample(1'b0, 16'sd1, res, lat);
    check("coef_we_busy_ignored", 64'(res), 17);

    // Full-scale negative: 16 * (-32768)^2 = 2^34
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'h8000);
    for (int i = 0; i < 16; i++) run_sample(1'b0, 16'h8000, res, lat);
    check("max_neg_out", 64'(res), 64'd17179869184);
    check("max_neg_lat", 64'(lat), 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilbert_fir_engine.md
HILBERT_FIR_ENGINE -- requirements
Module: hilbert_fir_engine

Interface
REQ-001 Parameter DW, 16, signed sample width.
REQ-002 Parameter CW, 16, signed coefficient width.
REQ-003 Parameter TAPS, 16, tap count; power of two, >= 4; AW = log2(TAPS); ACCW = DW+CW+AW.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 coef_we  in  1  coefficient write strobe.
REQ-007 coef_addr  in  AW  coefficient index k.
REQ-008 coef_data  in  CW  signed coefficient h[k].
REQ-009 mode  in  1  0 = full FIR, 1 = Hilbert (odd taps only).
REQ-010 clear  in  1  request to zero the delay line.
REQ-011 in_valid  in  1  sample offered.
REQ-012 in_data  in  DW  signed sample.
REQ-013 in_ready  out  1  sample accept enable.
REQ-014 out_valid  out  1  result available.
REQ-015 out_data  out  ACCW  signed result.
REQ-016 out_ready  in  1  downstream accepts result.
REQ-017 busy  out  1  high whenever state != IDLE.
REQ-018 done  out  1  one-cycle pulse on the output handshake.

Function
REQ-019 The FSM SHALL have states IDLE, CLEAR, MAC, OUT.
REQ-020 in_ready SHALL be combinational: (state == IDLE) && !clear.
REQ-021 In IDLE, clear = 1 SHALL move to CLEAR; clear takes priority over in_valid.
REQ-022 CLEAR SHALL zero one delay-line entry per cycle for TAPS cycles, reset wr_ptr to 0, then return to IDLE.
REQ-023 clear outside IDLE SHALL be ignored.
REQ-024 Accept = in_valid && in_ready: store in_data at x[wr_ptr], latch mode, clear acc, set k to 0 (mode 0) or 1 (mode 1), enter MAC.
REQ-025 MAC SHALL perform one product per cycle: acc += x[(wr_ptr - k) mod TAPS] * h[k], signed, full precision.
REQ-026 In MAC, k SHALL step by 1 (mode 0) or 2 (mode 1).
REQ-027 After the last tap (k = TAPS-1), the FSM SHALL load out_data = final acc, increment wr_ptr mod TAPS (wrap TAPS-1 -> 0), and enter OUT.
REQ-028 Latency: accept at cycle 0; out_valid SHALL rise at cycle TAPS+1 (mode 0) or TAPS/2+1 (mode 1).
REQ-029 OUT SHALL hold out_valid = 1 and out_data stable until out_ready = 1.
REQ-030 On that handshake, done SHALL pulse for one cycle and the FSM SHALL return to IDLE; back-to-back throughput is one sample per (taps processed + 2) cycles.
REQ-031 A mode change after accept SHALL have no effect on the sample in progress.
REQ-032 coef_we SHALL write h[coef_addr] only in IDLE and SHALL be ignored in other states.
REQ-033 A coefficient write in the same cycle as an accept SHALL take effect for that sample.
REQ-034 Arithmetic: two's complement, no saturation, no rounding; ACCW guarantees no overflow for any input values.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, wr_ptr = 0, k = 0, acc = 0, out_data = 0, out_valid = 0, done = 0, busy = 0.
REQ-036 rst_n low SHALL zero all delay-line and coefficient registers.
REQ-037 Reset asserted mid-MAC or in OUT SHALL abort with no out_valid or done.
REQ-038 in_ready SHALL be 1 from the first cycle after rst_n deasserts, unless clear is high.

Verification
REQ-039 TAPS = 16, mode 0, h[k] = k+1, impulse 1 followed by 15 zeros, out_ready = 1 -> outputs 1,2,...,16; each out_valid 17 cycles after its accept.
REQ-040 Mode 1, h[odd] = 100, h[even] = 500, impulse -> outputs 0,100,0,100,...; even taps never contribute; latency 9 cycles.
REQ-041 out_ready held 0 for 20 cycles in OUT -> out_valid and out_data stable, in_ready = 0, no done pulse; release -> single done pulse.
REQ-042 Fill with 0x7FFF samples; assert clear in IDLE together with in_valid -> no accept, busy for 16 cycles, next impulse response uncorrupted by old samples.
REQ-043 rst_n pulsed low at MAC cycle 5 -> outputs at reset values immediately; first post-reset sample gives a clean result.
REQ-044 All samples -32768, all h = -32768, mode 0 -> out_data = 16 * 2^30 = 2^34 exactly, no wrap.
